// File: rtl/ip_codma_states_pkg.sv
// ip_codma_states_pkg
//   Shared types and constants for the CODMA write machine.
//   - write_state_t : write FSM state encoding (WR_IDLE is all-zero so a
//                     cleared state register reads as idle)
//   - SZ_*          : legal transfer size codes
//   - size_to_words : size code -> number of 32-bit words, 0 if illegal
package ip_codma_states_pkg;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_ASK     = 3'd1,
    WR_GRANTED = 3'd2,
    WR_DONE    = 3'd3,
    WR_ERR     = 3'd4
  } write_state_t;

  localparam logic [3:0] SZ_2W = 4'd3;
  localparam logic [3:0] SZ_6W = 4'd8;
  localparam logic [3:0] SZ_8W = 4'd9;

  // A zero return doubles as the "illegal code" indication.
  function automatic logic [3:0] size_to_words(input logic [3:0] code);
    logic [3:0] words;
    case (code)
      SZ_2W:   words = 4'd2;
      SZ_6W:   words = 4'd6;
      SZ_8W:   words = 4'd8;
      default: words = 4'd0;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/ip_codma_wr_beat_mux.sv
// ip_codma_wr_beat_mux
//   Combinational beat selector: picks the two consecutive 32-bit words
//   starting at the word counter and packs them into one 64-bit beat,
//   higher-indexed word in the upper half.
// Ports:
//   cnt_i  - word index of the low word of the beat (always even in use)
//   buf_i  - latched word buffer, word 0 in [0]
//   data_o - {buf_i[cnt_i+1], buf_i[cnt_i]}
module ip_codma_wr_beat_mux #(
  parameter  int NUM_WORDS = 8,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic [IDX_W-1:0]          cnt_i,
  input  logic [NUM_WORDS-1:0][31:0] buf_i,
  output logic [63:0]               data_o
);

  logic [IDX_W-1:0] hi_idx;

  // cnt_i is even for every legal burst, so the +1 never wraps.
  assign hi_idx = cnt_i + IDX_W'(1);
  assign data_o = {buf_i[hi_idx], buf_i[cnt_i]};

endmodule

// File: rtl/ip_codma_write_machine.sv
// ip_codma_write_machine
//   Write-side engine of the CODMA. Snapshots the read machine's word
//   buffer, size code and destination address, requests the bus and
//   streams the words out as 64-bit beats, then reports done or error.
// Ports:
//   clk_i, reset_n_i       - clock, synchronous active-low reset
//   need_write_i           - start request (only looked at in WR_IDLE)
//   stop_i                 - abort, back to idle without touching the error flag
//   dma_error_i            - controller error, aborts and flags
//   data_reg_i             - word buffer, word 0 in [0]
//   wr_size_i, wr_addr_i   - size code and burst start address
//   bus_grant_i            - arbiter grant
//   bus_write_ready_i      - slave accepts the current beat
//   bus_error_i            - bus error, aborts and flags
//   bus_req_o, bus_write_o - bus request / write qualifier
//   bus_addr_o, bus_size_o - latched address and size code
//   bus_write_valid_o      - beat valid
//   bus_write_data_o       - current beat data
//   write_done_o           - one-cycle pulse at successful burst end
//   wr_state_error_o       - sticky error, cleared by the next accepted request
//   wr_state_r             - current FSM state
//
// state      | meaning
// WR_IDLE    | waiting for need_write_i, snapshot taken on acceptance
// WR_ASK     | bus requested, waiting for grant
// WR_GRANTED | streaming beats, cnt advances by 2 per accepted beat
// WR_DONE    | single-cycle done pulse, bus released
// WR_ERR     | illegal size code, flag set, return to idle
module ip_codma_write_machine
  import ip_codma_states_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      need_write_i,
  input  logic                      stop_i,
  input  logic                      dma_error_i,
  input  logic [NUM_WORDS-1:0][31:0] data_reg_i,
  input  logic [3:0]                wr_size_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic                      bus_grant_i,
  input  logic                      bus_write_ready_i,
  input  logic                      bus_error_i,
  output logic                      bus_req_o,
  output logic                      bus_write_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [3:0]                bus_size_o,
  output logic                      bus_write_valid_o,
  output logic [63:0]               bus_write_data_o,
  output logic                      write_done_o,
  output logic                      wr_state_error_o,
  output write_state_t              wr_state_r
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  write_state_t              state_q;
  logic [NUM_WORDS-1:0][31:0] buf_q;
  logic [3:0]                size_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [3:0]                cnt_q;
  logic [3:0]                cnt_d;
  logic [3:0]                target_words;
  logic                      req_q;
  logic                      valid_q;
  logic                      done_q;
  logic                      err_q;
  logic                      abort_err;

  assign target_words = size_to_words(size_q);
  assign cnt_d        = cnt_q + 4'd2;
  assign abort_err    = (bus_error_i | dma_error_i) & (state_q != WR_IDLE);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= WR_IDLE;
      buf_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (stop_i) begin
      state_q <= WR_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort_err) begin
      state_q <= WR_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WR_IDLE: begin
          if (need_write_i) begin
            buf_q  <= data_reg_i;
            size_q <= wr_size_i;
            addr_q <= wr_addr_i;
            cnt_q  <= '0;
            if (size_to_words(wr_size_i) != 4'd0) begin
              state_q <= WR_ASK;
              req_q   <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              // Flag goes up on entry so it is already visible in WR_ERR.
              state_q <= WR_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        WR_ASK: begin
          if (bus_grant_i) begin
            state_q <= WR_GRANTED;
            valid_q <= 1'b1;
          end
        end
        WR_GRANTED: begin
          if (bus_write_ready_i) begin
            cnt_q <= cnt_d;
            if (cnt_d == target_words) begin
              state_q <= WR_DONE;
              req_q   <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        WR_DONE: begin
          state_q <= WR_IDLE;
        end
        WR_ERR: begin
          state_q <= WR_IDLE;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= WR_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  ip_codma_wr_beat_mux #(
    .NUM_WORDS (NUM_WORDS)
  ) u_beat_mux (
    .cnt_i  (cnt_q[IDX_W-1:0]),
    .buf_i  (buf_q),
    .data_o (bus_write_data_o)
  );

  assign bus_req_o         = req_q;
  assign bus_write_o       = req_q;
  assign bus_addr_o        = addr_q;
  assign bus_size_o        = size_q;
  assign bus_write_valid_o = valid_q;
  assign write_done_o      = done_q;
  assign wr_state_error_o  = err_q;
  assign wr_state_r        = state_q;

endmodule

// File: tb/tb_ip_codma_write_machine.sv
module tb_ip_codma_write_machine;
  import ip_codma_states_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              need_write_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              dma_error_i = 1'b0;
  logic [7:0][31:0]  data_reg_i = '0;
  logic [3:0]        wr_size_i = '0;
  logic [31:0]       wr_addr_i = '0;
  logic              bus_grant_i = 1'b0;
  logic              bus_write_ready_i = 1'b0;
  logic              bus_error_i = 1'b0;
  logic              bus_req_o;
  logic              bus_write_o;
  logic [31:0]       bus_addr_o;
  logic [3:0]        bus_size_o;
  logic              bus_write_valid_o;
  logic [63:0]       bus_write_data_o;
  logic              write_done_o;
  logic              wr_state_error_o;
  write_state_t      wr_state_r;

  ip_codma_write_machine #(.ADDR_W(32), .NUM_WORDS(8)) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .need_write_i      (need_write_i),
    .stop_i            (stop_i),
    .dma_error_i       (dma_error_i),
    .data_reg_i        (data_reg_i),
    .wr_size_i         (wr_size_i),
    .wr_addr_i         (wr_addr_i),
    .bus_grant_i       (bus_grant_i),
    .bus_write_ready_i (bus_write_ready_i),
    .bus_error_i       (bus_error_i),
    .bus_req_o         (bus_req_o),
    .bus_write_o       (bus_write_o),
    .bus_addr_o        (bus_addr_o),
    .bus_size_o        (bus_size_o),
    .bus_write_valid_o (bus_write_valid_o),
    .bus_write_data_o  (bus_write_data_o),
    .write_done_o      (write_done_o),
    .wr_state_error_o  (wr_state_error_o),
    .wr_state_r        (wr_state_r)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  int          beats_seen = 0;
  int          done_cnt = 0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops expected beats on handshake.
  always @(negedge clk_i) begin
    if (hold_v) begin
      check("stall_valid", {63'd0, bus_write_valid_o}, 64'd1);
      check("stall_data", bus_write_data_o, hold_d);
    end
    hold_v = bus_write_valid_o && !bus_write_ready_i;
    hold_d = bus_write_data_o;
    if (bus_write_valid_o && bus_write_ready_i) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL beat_unexpected: got %0h, expected no beat", bus_write_data_o);
      end else begin
        check("beat_data", bus_write_data_o, exp_q.pop_front());
      end
    end
    if (write_done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_state(input write_state_t st, input int budget, input bit tog);
    for (int i = 0; i < budget; i++) begin
      if (wr_state_r == st) break;
      if (tog) bus_write_ready_i = ~bus_write_ready_i;
      tick();
    end
    check("wait_state", 64'(wr_state_r), 64'(st));
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) data_reg_i[i] = base + 32'(i);
  endtask

  task automatic start(input logic [3:0] sz, input logic [31:0] addr);
    wr_size_i    = sz;
    wr_addr_i    = addr;
    need_write_i = 1'b1;
    tick();
    need_write_i = 1'b0;
  endtask

  int b0;
  int d0;

  initial begin
    // reset
    tick();
    tick();
    check("rst_state", 64'(wr_state_r), 64'(WR_IDLE));
    check("rst_req", {63'd0, bus_req_o}, 64'd0);
    check("rst_valid", {63'd0, bus_write_valid_o}, 64'd0);
    check("rst_data", bus_write_data_o, 64'd0);
    check("rst_err", {63'd0, wr_state_error_o}, 64'd0);
    reset_n_i = 1'b1;
    tick();

    // T1: size 9, grant after 2 cycles, ready high
    for (int i = 0; i < 8; i++) data_reg_i[i] = 32'(32'h11 * (i + 1));
    bus_write_ready_i = 1'b1;
    exp_q.push_back({32'h22, 32'h11});
    exp_q.push_back({32'h44, 32'h33});
    exp_q.push_back({32'h66, 32'h55});
    exp_q.push_back({32'h88, 32'h77});
    d0 = done_cnt;
    start(SZ_8W, 32'h1000_0040);
    check("t1_ask", 64'(wr_state_r), 64'(WR_ASK));
    check("t1_req", {62'd0, bus_req_o, bus_write_o}, 64'd3);
    check("t1_addr", 64'(bus_addr_o), 64'h1000_0040);
    check("t1_size", 64'(bus_size_o), 64'd9);
    tick();
    tick();
    check("t1_still_ask", 64'(wr_state_r), 64'(WR_ASK));
    bus_grant_i = 1'b1;
    tick();
    check("t1_granted", 64'(wr_state_r), 64'(WR_GRANTED));
    wait_state(WR_DONE, 20, 1'b0);
    check("t1_done_pulse", {63'd0, write_done_o}, 64'd1);
    check("t1_req_fall", {62'd0, bus_req_o, bus_write_valid_o}, 64'd0);
    tick();
    check("t1_idle", 64'(wr_state_r), 64'(WR_IDLE));
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // T2: size 8, ready toggling
    fill(32'hA0);
    exp_q.push_back({32'hA1, 32'hA0});
    exp_q.push_back({32'hA3, 32'hA2});
    exp_q.push_back({32'hA5, 32'hA4});
    b0 = beats_seen;
    d0 = done_cnt;
    start(SZ_6W, 32'h2000_0000);
    wait_state(WR_DONE, 40, 1'b1);
    bus_write_ready_i = 1'b1;
    tick();
    check("t2_beats", 64'(beats_seen - b0), 64'd3);
    check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // T3: illegal size
    start(4'd5, 32'h3000_0000);
    check("t3_err_state", 64'(wr_state_r), 64'(WR_ERR));
    check("t3_req", {63'd0, bus_req_o}, 64'd0);
    tick();
    check("t3_idle", 64'(wr_state_r), 64'(WR_IDLE));
    check("t3_flag", {63'd0, wr_state_error_o}, 64'd1);
    check("t3_req2", {63'd0, bus_req_o}, 64'd0);

    // T4: bus error on beat 2; starting it clears the flag
    fill(32'hB0);
    exp_q.push_back({32'hB1, 32'hB0});
    exp_q.push_back({32'hB3, 32'hB2});
    d0 = done_cnt;
    start(SZ_8W, 32'h4000_0000);
    check("t4_flag_clear", {63'd0, wr_state_error_o}, 64'd0);
    tick();
    tick();
    bus_error_i = 1'b1;
    tick();
    bus_error_i = 1'b0;
    check("t4_idle", 64'(wr_state_r), 64'(WR_IDLE));
    check("t4_flag", {63'd0, wr_state_error_o}, 64'd1);
    check("t4_valid", {62'd0, bus_write_valid_o, bus_req_o}, 64'd0);
    tick();
    check("t4_no_done", 64'(done_cnt - d0), 64'd0);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // T5: size 3, stop in WR_ASK, then restart with buffer changed after start
    bus_grant_i = 1'b0;
    fill(32'hC0);
    b0 = beats_seen;
    start(SZ_2W, 32'h5000_0000);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("t5_idle", 64'(wr_state_r), 64'(WR_IDLE));
    check("t5_flag", {63'd0, wr_state_error_o}, 64'd0);
    check("t5_no_beats", 64'(beats_seen - b0), 64'd0);
    exp_q.push_back({32'hC1, 32'hC0});
    d0 = done_cnt;
    start(SZ_2W, 32'h5000_0000);
    fill(32'hE0);
    bus_grant_i = 1'b1;
    wait_state(WR_DONE, 20, 1'b0);
    tick();
    check("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // T6: reset glitch between edges ignored, real reset mid-burst clears all
    fill(32'hF0);
    exp_q.push_back({32'hF1, 32'hF0});
    exp_q.push_back({32'hF3, 32'hF2});
    start(SZ_8W, 32'h6000_0000);
    tick();
    reset_n_i = 1'b0;
    #2;
    reset_n_i = 1'b1;
    tick();
    check("t6_glitch_state", 64'(wr_state_r), 64'(WR_GRANTED));
    check("t6_glitch_req", {63'd0, bus_req_o}, 64'd1);
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    check("t6_state", 64'(wr_state_r), 64'(WR_IDLE));
    check("t6_ctl", {59'd0, bus_req_o, bus_write_o, bus_write_valid_o, write_done_o, wr_state_error_o}, 64'd0);
    check("t6_addr", 64'(bus_addr_o), 64'd0);
    check("t6_size", 64'(bus_size_o), 64'd0);
    check("t6_data", bus_write_data_o, 64'd0);
    tick();
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_codma_write_machine.md
Name: ip_codma_write_machine

Overview:
- Write-side engine of the CODMA, directly downstream of the read machine.
- Takes the 8x32-bit word buffer the read machine fills, plus the transfer size and destination address.
- Requests the system bus, then streams the words out as 64-bit write beats.
- Reports completion or error back to the DMA controller.

Parameters:
ADDR_W, 32, destination address width
NUM_WORDS, 8, depth of the 32-bit word buffer (fixed; beat = 2 words)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; synchronous, active-low
need_write_i  in  1  start request from DMA controller, sampled in WR_IDLE only
stop_i  in  1  abort current transfer
dma_error_i  in  1  DMA controller is in its error state
data_reg_i  in  8x32  word buffer from read machine, word 0 in [0]
wr_size_i  in  4  size code: 3 = 2 words, 8 = 6 words, 9 = 8 words
wr_addr_i  in  ADDR_W  burst start address
bus_grant_i  in  1  arbiter grant
bus_write_ready_i  in  1  slave accepts current beat
bus_error_i  in  1  bus error
bus_req_o  out  1  bus request
bus_write_o  out  1  write qualifier, high with bus_req_o
bus_addr_o  out  ADDR_W  latched address
bus_size_o  out  4  latched size code
bus_write_valid_o  out  1  beat valid
bus_write_data_o  out  64  {word[cnt+1], word[cnt]}
write_done_o  out  1  one-cycle pulse on successful burst end
wr_state_error_o  out  1  sticky error flag
wr_state_r  out  write_state_t  current state

Behaviour:
- Reset (synchronous, reset_n_i low at a clock edge):
  - State goes to WR_IDLE.
  - Every output and the word counter go to 0, including the latched address, size and data.
- Priority each cycle: reset > stop_i > (bus_error_i | dma_error_i) > normal FSM.
  - stop_i: go to WR_IDLE. No done pulse, error flag unchanged.
  - bus_error_i or dma_error_i while not in WR_IDLE: go to WR_IDLE and set wr_state_error_o. No done pulse.
- State encoding (write_state_t): WR_IDLE, WR_ASK, WR_GRANTED, WR_DONE, WR_ERR.
- WR_IDLE:
  - On need_write_i, snapshot data_reg_i, wr_size_i and wr_addr_i into internal registers. The read machine may refill its buffer from the next cycle.
  - Clear wr_state_error_o and the word counter.
  - Size code 3, 8 or 9: go to WR_ASK. Any other code: go to WR_ERR.
- WR_ASK:
  - bus_req_o and bus_write_o are 1; bus_addr_o and bus_size_o carry the latched values.
  - bus_grant_i high: go to WR_GRANTED.
- WR_GRANTED:
  - bus_req_o stays 1. bus_write_valid_o = 1. bus_write_data_o = {buf[cnt+1], buf[cnt]}.
  - A beat completes on valid & ready; cnt += 2 on that edge.
  - When a beat completes with cnt+2 == target word count (2/6/8), go to WR_DONE.
  - Data and valid hold unchanged while ready is low; there is no timeout.
- WR_DONE: write_done_o = 1 for exactly this cycle; bus_req_o and valid are 0. Next state: WR_IDLE.
- WR_ERR: set wr_state_error_o; next state WR_IDLE. The flag stays set until the next accepted need_write_i.
- Address is constant for the whole burst; beat addressing is the slave's job.
- Counter is 4 bits. Beat index is cnt/2, so there is no wrap-around within a legal size.
- Latency (grant and ready tied high, need_write_i at cycle 0):
  - bus_req_o rises in cycle 1; WR_GRANTED in cycle 2.
  - 8-word burst: beats in cycles 2-5, write_done_o in cycle 6, WR_IDLE in cycle 7.
- need_write_i held high through a burst is ignored until WR_IDLE. A request still high in WR_IDLE starts a new burst. A request arriving on the same cycle as WR_DONE is not lost: it is sampled in the following WR_IDLE cycle.

Decomposition:
- ip_codma_states_pkg holds:
  - write_state_t;
  - size-code constants SZ_2W=3, SZ_6W=8, SZ_8W=9;
  - a function mapping a size code to its word count, returning 0 for an illegal code.
- One natural sub-module: ip_codma_wr_beat_mux. It is combinational: counter plus latched buffer in, 64-bit beat data out.
- FSM, snapshot registers and counter stay in the top module.

Test Plan:
- Size 9, words 0x11..0x88, grant after 2 cycles, ready=1 -> 4 beats {0x22,0x11},{0x44,0x33},{0x66,0x55},{0x88,0x77}; one done pulse; bus_req_o falls in WR_DONE.
- Size 8, ready toggling 1/0 -> exactly 3 accepted beats; data stable while ready=0; done pulse after beat 3; words 6-7 never driven.
- Size 5 -> WR_ERR then WR_IDLE; wr_state_error_o=1; bus_req_o never asserted; next legal request clears the flag.
- Size 9, bus_error_i on beat 2 -> WR_IDLE next cycle, error flag set, no done pulse, bus_write_valid_o=0.
- Size 3, stop_i in WR_ASK -> WR_IDLE, no beats, flag unchanged; data_reg_i changed after start does not alter the beats of an immediate restart.
- reset_n_i low for one edge mid-burst -> all outputs 0 and WR_IDLE on that edge; reset deasserted between edges has no effect.
